// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, result-broadcast and ALU-issue bundle
// for the integer ALU reservation station.
interface alu_rs_if #(
    parameter int ROB_W = 5
);
    logic             in_valid;
    logic [4:0]       in_work_type;
    logic [ROB_W-1:0] in_rob_id;
    logic             in_q1_busy;
    logic             in_q2_busy;
    logic [ROB_W-1:0] in_q1;
    logic [ROB_W-1:0] in_q2;
    logic [31:0]      in_v1;
    logic [31:0]      in_v2;
    logic             cdb_alu_valid;
    logic [ROB_W-1:0] cdb_alu_rob;
    logic [31:0]      cdb_alu_value;
    logic             cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_lsb_rob;
    logic [31:0]      cdb_lsb_value;
    logic             full;
    logic             alu_valid;
    logic [4:0]       alu_work_type;
    logic [31:0]      alu_r1;
    logic [31:0]      alu_r2;
    logic [ROB_W-1:0] alu_rob_id;

    modport master (
        output in_valid, in_work_type, in_rob_id,
        output in_q1_busy, in_q2_busy, in_q1, in_q2,
        output in_v1, in_v2,
        output cdb_alu_valid, cdb_alu_rob, cdb_alu_value,
        output cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_value,
        input  full, alu_valid, alu_work_type,
        input  alu_r1, alu_r2, alu_rob_id
    );

    modport slave (
        input  in_valid, in_work_type, in_rob_id,
        input  in_q1_busy, in_q2_busy, in_q1, in_q2,
        input  in_v1, in_v2,
        input  cdb_alu_valid, cdb_alu_rob, cdb_alu_value,
        input  cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_value,
        output full, alu_valid, alu_work_type,
        output alu_r1, alu_r2, alu_rob_id
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station and in-order-by-slot issue
// scheduler feeding the single-cycle integer ALU.
`ifndef ROBSIZE
`define ROBSIZE 5
`endif

module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = `ROBSIZE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    input  logic flush,
    alu_rs_if.slave bus
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] q1b_q, q1b_d;
    logic [RS_SIZE-1:0] q2b_q, q2b_d;
    logic [4:0]       wt_q  [RS_SIZE];
    logic [4:0]       wt_d  [RS_SIZE];
    logic [ROB_W-1:0] rob_q [RS_SIZE];
    logic [ROB_W-1:0] rob_d [RS_SIZE];
    logic [ROB_W-1:0] q1_q  [RS_SIZE];
    logic [ROB_W-1:0] q1_d  [RS_SIZE];
    logic [ROB_W-1:0] q2_q  [RS_SIZE];
    logic [ROB_W-1:0] q2_d  [RS_SIZE];
    logic [31:0]      v1_q  [RS_SIZE];
    logic [31:0]      v1_d  [RS_SIZE];
    logic [31:0]      v2_q  [RS_SIZE];
    logic [31:0]      v2_d  [RS_SIZE];

    logic             alu_valid_q, alu_valid_d;
    logic [4:0]       alu_wt_q, alu_wt_d;
    logic [31:0]      alu_r1_q, alu_r1_d;
    logic [31:0]      alu_r2_q, alu_r2_d;
    logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

    logic [RS_SIZE-1:0] ready;
    logic               iss_any;
    logic [IW-1:0]      iss_idx;
    logic [IW-1:0]      free_idx;
    logic               full;

    // Returns {still_busy, value}; ALU broadcast beats LSB.
    function automatic logic [32:0] snoop(
        input logic             b,
        input logic [ROB_W-1:0] t,
        input logic [31:0]      v,
        input logic             av,
        input logic [ROB_W-1:0] at,
        input logic [31:0]      ad,
        input logic             lv,
        input logic [ROB_W-1:0] lt,
        input logic [31:0]      ld
    );
        if (b && av && at == t) return {1'b0, ad};
        if (b && lv && lt == t) return {1'b0, ld};
        return {b, v};
    endfunction

    assign full              = &busy_q;
    assign bus.full          = full;
    assign bus.alu_valid     = alu_valid_q;
    assign bus.alu_work_type = alu_wt_q;
    assign bus.alu_r1        = alu_r1_q;
    assign bus.alu_r2        = alu_r2_q;
    assign bus.alu_rob_id    = alu_rob_q;

    // Lowest-index ready entry and lowest-index free slot.
    always_comb begin
        ready    = busy_q & ~q1b_q & ~q2b_q;
        iss_any  = |ready;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) iss_idx = IW'(i);
            if (!busy_q[i]) free_idx = IW'(i);
        end
    end

    // Next state: flush, else wakeup + issue + dispatch.
    always_comb begin
        busy_d      = busy_q;
        q1b_d       = q1b_q;
        q2b_d       = q2b_q;
        wt_d        = wt_q;
        rob_d       = rob_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        alu_valid_d = alu_valid_q;
        alu_wt_d    = alu_wt_q;
        alu_r1_d    = alu_r1_q;
        alu_r2_d    = alu_r2_q;
        alu_rob_d   = alu_rob_q;
        if (rdy) begin
            if (flush) begin
                busy_d      = '0;
                alu_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        {q1b_d[i], v1_d[i]} = snoop(
                            q1b_q[i], q1_q[i], v1_q[i],
                            bus.cdb_alu_valid, bus.cdb_alu_rob,
                            bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_rob,
                            bus.cdb_lsb_value);
                        {q2b_d[i], v2_d[i]} = snoop(
                            q2b_q[i], q2_q[i], v2_q[i],
                            bus.cdb_alu_valid, bus.cdb_alu_rob,
                            bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_rob,
                            bus.cdb_lsb_value);
                    end
                end
                alu_valid_d = iss_any;
                if (iss_any) begin
                    busy_d[iss_idx] = 1'b0;
                    alu_wt_d        = wt_q[iss_idx];
                    alu_r1_d        = v1_q[iss_idx];
                    alu_r2_d        = v2_q[iss_idx];
                    alu_rob_d       = rob_q[iss_idx];
                end
                if (bus.in_valid && !full) begin
                    busy_d[free_idx] = 1'b1;
                    wt_d[free_idx]   = bus.in_work_type;
                    rob_d[free_idx]  = bus.in_rob_id;
                    q1_d[free_idx]   = bus.in_q1;
                    q2_d[free_idx]   = bus.in_q2;
                    {q1b_d[free_idx], v1_d[free_idx]} = snoop(
                        bus.in_q1_busy, bus.in_q1, bus.in_v1,
                        bus.cdb_alu_valid, bus.cdb_alu_rob,
                        bus.cdb_alu_value,
                        bus.cdb_lsb_valid, bus.cdb_lsb_rob,
                        bus.cdb_lsb_value);
                    {q2b_d[free_idx], v2_d[free_idx]} = snoop(
                        bus.in_q2_busy, bus.in_q2, bus.in_v2,
                        bus.cdb_alu_valid, bus.cdb_alu_rob,
                        bus.cdb_alu_value,
                        bus.cdb_lsb_valid, bus.cdb_lsb_rob,
                        bus.cdb_lsb_value);
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            q1b_q       <= '0;
            q2b_q       <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                wt_q[i]  <= '0;
                rob_q[i] <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_wt_q    <= '0;
            alu_r1_q    <= '0;
            alu_r2_q    <= '0;
            alu_rob_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            q1b_q       <= q1b_d;
            q2b_q       <= q2b_d;
            wt_q        <= wt_d;
            rob_q       <= rob_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            alu_valid_q <= alu_valid_d;
            alu_wt_q    <= alu_wt_d;
            alu_r1_q    <= alu_r1_d;
            alu_r2_q    <= alu_r2_d;
            alu_rob_q   <= alu_rob_d;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model.
module tb_alu_rs;
    localparam int RS = 8;
    localparam int RW = 5;

    logic clk;
    logic rst_n;
    logic rdy;
    logic flush;

    alu_rs_if #(.ROB_W(RW)) bus ();

    alu_rs #(.RS_SIZE(RS), .ROB_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [4:0]  wt;
        logic [RW-1:0] rob;
        bit          q1b;
        logic [RW-1:0] q1;
        logic [31:0] v1;
        bit          q2b;
        logic [RW-1:0] q2;
        logic [31:0] v2;
    } ent_t;

    ent_t          m [RS];
    bit            m_valid;
    logic [4:0]    m_wt;
    logic [31:0]   m_r1;
    logic [31:0]   m_r2;
    logic [RW-1:0] m_rob;

    int nvec = 0;
    int nerr = 0;

    task automatic check(string tag, logic [63:0] obs,
                         logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < RS; i++)
            if (!m[i].busy) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m[i].busy = 0;
        m_valid = 0;
        m_wt    = '0;
        m_r1    = '0;
        m_r2    = '0;
        m_rob   = '0;
    endtask

    function automatic bit cdb_hit(input logic [RW-1:0] tag,
                                   output logic [31:0] val);
        val = '0;
        if (bus.cdb_alu_valid && bus.cdb_alu_rob == tag) begin
            val = bus.cdb_alu_value;
            return 1;
        end
        if (bus.cdb_lsb_valid && bus.cdb_lsb_rob == tag) begin
            val = bus.cdb_lsb_value;
            return 1;
        end
        return 0;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step();
        ent_t pre [RS];
        ent_t e;
        int sel;
        int fr;
        bit was_full;
        logic [31:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            m_valid = 0;
            return;
        end
        pre = m;
        was_full = m_full();
        sel = -1;
        fr = -1;
        for (int i = 0; i < RS; i++) begin
            if (sel < 0 && pre[i].busy && !pre[i].q1b
                && !pre[i].q2b) sel = i;
            if (fr < 0 && !pre[i].busy) fr = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (!m[i].busy) continue;
            if (m[i].q1b && cdb_hit(m[i].q1, v)) begin
                m[i].q1b = 0;
                m[i].v1 = v;
            end
            if (m[i].q2b && cdb_hit(m[i].q2, v)) begin
                m[i].q2b = 0;
                m[i].v2 = v;
            end
        end
        if (sel >= 0) begin
            m_valid = 1;
            m_wt  = pre[sel].wt;
            m_r1  = pre[sel].v1;
            m_r2  = pre[sel].v2;
            m_rob = pre[sel].rob;
            m[sel].busy = 0;
        end else begin
            m_valid = 0;
        end
        if (bus.in_valid && !was_full) begin
            e.busy = 1;
            e.wt  = bus.in_work_type;
            e.rob = bus.in_rob_id;
            e.q1  = bus.in_q1;
            e.q2  = bus.in_q2;
            e.q1b = bus.in_q1_busy;
            e.v1  = bus.in_v1;
            e.q2b = bus.in_q2_busy;
            e.v2  = bus.in_v2;
            if (e.q1b && cdb_hit(e.q1, v)) begin
                e.q1b = 0;
                e.v1 = v;
            end
            if (e.q2b && cdb_hit(e.q2, v)) begin
                e.q2b = 0;
                e.v2 = v;
            end
            m[fr] = e;
        end
    endtask

    task automatic chk_all();
        check("full", bus.full, m_full());
        check("valid", bus.alu_valid, m_valid);
        check("work_type", bus.alu_work_type, m_wt);
        check("r1", bus.alu_r1, m_r1);
        check("r2", bus.alu_r2, m_r2);
        check("rob", bus.alu_rob_id, m_rob);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk_all();
    endtask

    task automatic idle();
        bus.in_valid      = 0;
        bus.cdb_alu_valid = 0;
        bus.cdb_lsb_valid = 0;
    endtask

    task automatic disp(input logic [4:0] wt,
                        input logic [RW-1:0] rob,
                        input logic q1b, input logic [RW-1:0] q1,
                        input logic [31:0] v1,
                        input logic q2b, input logic [RW-1:0] q2,
                        input logic [31:0] v2);
        bus.in_valid     = 1;
        bus.in_work_type = wt;
        bus.in_rob_id    = rob;
        bus.in_q1_busy   = q1b;
        bus.in_q1        = q1;
        bus.in_v1        = v1;
        bus.in_q2_busy   = q2b;
        bus.in_q2        = q2;
        bus.in_v2        = v2;
    endtask

    initial begin
        rst_n = 0;
        rdy   = 1;
        flush = 0;
        idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid      = 0;
        bus.cdb_alu_rob   = '0;
        bus.cdb_alu_value = '0;
        bus.cdb_lsb_rob   = '0;
        bus.cdb_lsb_value = '0;
        model_reset();

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        check("por_valid", bus.alu_valid, 0);
        check("por_full", bus.full, 0);
        rst_n = 1;

        // Activity, then reset mid-stream with 3 busy entries.
        disp(5'd1, 5'd1, 0, 0, 32'd5, 0, 0, 32'd7);
        tick();
        idle();
        tick();
        check("pre_valid", bus.alu_valid, 1);
        for (int i = 0; i < 3; i++) begin
            disp(5'd1, RW'(2 + i), 1, 5'd20, 0, 0, 0, i);
            tick();
        end
        idle();
        tick();
        rst_n = 0;
        #2;
        model_reset();
        check("mrst_valid", bus.alu_valid, 0);
        check("mrst_r1", bus.alu_r1, 0);
        check("mrst_r2", bus.alu_r2, 0);
        check("mrst_rob", bus.alu_rob_id, 0);
        check("mrst_full", bus.full, 0);
        tick();
        rst_n = 1;
        disp(5'd1, 5'd4, 0, 0, 32'd5, 0, 0, 32'd7);
        tick();
        check("add_lat0", bus.alu_valid, 0);
        idle();
        tick();
        check("add_valid", bus.alu_valid, 1);
        check("add_r1", bus.alu_r1, 5);
        check("add_r2", bus.alu_r2, 7);

        // Wakeup from the LSB broadcast.
        disp(5'b00010, 5'd7, 1, 5'd3, 0, 0, 0, 32'd1);
        tick();
        idle();
        tick();
        bus.cdb_lsb_valid = 1;
        bus.cdb_lsb_rob   = 5'd3;
        bus.cdb_lsb_value = 32'd10;
        tick();
        check("wk_early", bus.alu_valid, 0);
        idle();
        tick();
        check("wk_valid", bus.alu_valid, 1);
        check("wk_r1", bus.alu_r1, 10);
        check("wk_r2", bus.alu_r2, 1);
        check("wk_wt", bus.alu_work_type, 2);

        // Dispatch-time bypass from the ALU broadcast.
        disp(5'd1, 5'd8, 0, 0, 32'd3, 1, 5'd6, 0);
        bus.cdb_alu_valid = 1;
        bus.cdb_alu_rob   = 5'd6;
        bus.cdb_alu_value = 32'hFFFF_FFFF;
        tick();
        idle();
        tick();
        check("byp_valid", bus.alu_valid, 1);
        check("byp_r2", bus.alu_r2, 32'hFFFF_FFFF);

        // Fill all slots, refuse a ninth, drain in slot order.
        for (int i = 0; i < RS; i++) begin
            disp(5'd1, RW'(16 + i), 1, 5'd9, 0, 0, 0, i);
            tick();
        end
        check("fill_full", bus.full, 1);
        disp(5'd1, 5'd30, 0, 0, 32'h99, 0, 0, 32'h99);
        tick();
        check("fill_full2", bus.full, 1);
        idle();
        bus.cdb_alu_valid = 1;
        bus.cdb_alu_rob   = 5'd9;
        bus.cdb_alu_value = 32'h100;
        tick();
        idle();
        for (int i = 0; i < RS; i++) begin
            tick();
            check("drain_valid", bus.alu_valid, 1);
            check("drain_r2", bus.alu_r2, i);
            check("drain_rob", bus.alu_rob_id, 16 + i);
            if (i == 0) check("drain_full", bus.full, 0);
        end
        tick();
        check("drain_end", bus.alu_valid, 0);

        // Flush with 4 busy entries.
        for (int i = 0; i < 4; i++) begin
            disp(5'd3, RW'(1 + i), 1, 5'd11, 0, 0, 0, i);
            tick();
        end
        idle();
        bus.cdb_lsb_valid = 1;
        bus.cdb_lsb_rob   = 5'd11;
        bus.cdb_lsb_value = 32'h55;
        tick();
        idle();
        tick();
        check("fl_pre", bus.alu_valid, 1);
        flush = 1;
        tick();
        check("fl_valid", bus.alu_valid, 0);
        check("fl_full", bus.full, 0);
        flush = 0;
        repeat (3) begin
            tick();
            check("fl_quiet", bus.alu_valid, 0);
        end

        // rdy low holds everything for 3 cycles.
        disp(5'd1, 5'd12, 0, 0, 32'h1234, 0, 0, 32'h4321);
        tick();
        rdy = 0;
        disp(5'd1, 5'd13, 0, 0, 32'hAAAA, 0, 0, 32'hBBBB);
        repeat (3) begin
            tick();
            check("rdy_valid", bus.alu_valid, 0);
            check("rdy_hold", bus.alu_r1, 32'h55);
        end
        idle();
        rdy = 1;
        tick();
        check("rdy_iss", bus.alu_valid, 1);
        check("rdy_r1", bus.alu_r1, 32'h1234);
        check("rdy_rob", bus.alu_rob_id, 12);
        tick();
        check("rdy_once", bus.alu_valid, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            bus.in_valid = 0;
            if (!m_full() && $urandom_range(0, 2) != 0)
                disp(5'($urandom), 5'($urandom),
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), $urandom);
            bus.cdb_alu_valid = ($urandom_range(0, 4) < 2);
            bus.cdb_alu_rob   = 5'($urandom_range(0, 7));
            bus.cdb_alu_value = $urandom;
            bus.cdb_lsb_valid = ($urandom_range(0, 4) < 2);
            bus.cdb_lsb_rob   = 5'($urandom_range(0, 7));
            bus.cdb_lsb_value = $urandom;
            tick();
        end
        idle();
        rdy   = 1;
        flush = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end
endmodule
